// File: rtl/datapath_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | datapath_unit_if                                                   |
// | Control word, memory read data and datapath result bundle.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface datapath_unit_if;
    logic [3:0]  DR;
    logic [3:0]  SA;
    logic [3:0]  SB;
    logic        MB;
    logic        MD;
    logic        RW;
    logic [3:0]  FS;
    logic [15:0] data_in;
    logic [15:0] A_bus;
    logic [15:0] B_bus;
    logic [15:0] F;
    logic        Z;
    logic [3:0]  status;

    modport master (
        output DR, SA, SB, MB, MD, RW, FS, data_in,
        input  A_bus, B_bus, F, Z, status
    );

    modport slave (
        input  DR, SA, SB, MB, MD, RW, FS, data_in,
        output A_bus, B_bus, F, Z, status
    );
endinterface
`default_nettype wire

// File: rtl/datapath_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | datapath_unit                                                      |
// | 16x16 register file, operand muxes, ALU/shifter and status flags.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module datapath_unit (
    input  logic            clk,
    input  logic            reset,
    datapath_unit_if.slave  bus
);

    logic [15:0] r_regs [0:15];
    logic [3:0]  r_status;

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_y;
    logic        w_cin;
    logic [16:0] w_sum;
    logic [15:0] w_f;
    logic        w_c;
    logic        w_v;
    logic        w_z;
    logic [15:0] w_wb;

    assign w_a = r_regs[bus.SA];
    assign w_b = bus.MB ? {12'b0, bus.SB} : r_regs[bus.SB];

    // Every arithmetic code is A + y + cin, so one adder covers all eight.
    always_comb begin
        w_y   = 16'h0000;
        w_cin = 1'b0;
        case (bus.FS[2:0])
            3'b001:  w_cin = 1'b1;
            3'b010:  w_y   = w_b;
            3'b011:  begin w_y = w_b;  w_cin = 1'b1; end
            3'b100:  w_y   = ~w_b;
            3'b101:  begin w_y = ~w_b; w_cin = 1'b1; end
            3'b110:  w_y   = 16'hFFFF;
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_y} + {16'h0000, w_cin};

    always_comb begin
        w_f = 16'h0000;
        w_c = 1'b0;
        w_v = 1'b0;
        if (!bus.FS[3]) begin
            w_f = w_sum[15:0];
            w_c = w_sum[16];
            w_v = (w_a[15] == w_y[15]) && (w_sum[15] != w_a[15]);
        end else begin
            case (bus.FS[2:0])
                3'b000:  w_f = w_a & w_b;
                3'b001:  w_f = w_a | w_b;
                3'b010:  w_f = w_a ^ w_b;
                3'b011:  w_f = ~w_a;
                3'b100:  w_f = w_b;
                3'b101:  begin w_f = {1'b0, w_b[15:1]}; w_c = w_b[0];  end
                3'b110:  begin w_f = {w_b[14:0], 1'b0}; w_c = w_b[15]; end
                default: w_f = 16'h0000;
            endcase
        end
    end

    assign w_z  = (w_f == 16'h0000);
    assign w_wb = bus.MD ? bus.data_in : w_f;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (bus.RW) begin
            r_regs[bus.DR] <= w_wb;
        end
    end

    // Flags track ALU write-backs only; memory loads leave them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= 4'b0000;
        end else if (bus.RW && !bus.MD) begin
            r_status <= {w_v, w_c, w_f[15], w_z};
        end
    end

    assign bus.A_bus  = w_a;
    assign bus.B_bus  = w_b;
    assign bus.F      = w_f;
    assign bus.Z      = w_z;
    assign bus.status = r_status;

endmodule
`default_nettype wire
